dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the processor's data-memory port. Accepts the `address_dmem` / `data` / `wren` request signals the processor drives and returns `q_dmem` with fixed one-cycle read latency, matching the syncram timing the processor is built around. Backs the low address space with a word RAM. Optionally decodes a small memory-mapped I/O window at the top of the address space. Drop-in replacement for `dmem` in `skeleton`, clocked from the same inverted clock.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width.
- `DATA_W`, 32: word width.
- `MMIO_WORDS`, 4: words at the top of the address space claimed by MMIO when enabled; must be a power of two, ≥4.

Ports:
- `clock`  in  1: sole clock; all state changes on its rising edge. `skeleton` connects `~clock`.
- `reset`  in  1: asynchronous, active-high.
- `address`  in  ADDR_W: word address.
- `data`  in  DATA_W: write data.
- `wren`  in  1: write enable, sampled at the clock edge.
- `q`  out  DATA_W: read data, registered.
- `mmio_led`  out  DATA_W: LED/scratch register, 0 when `MMIO` is compiled out.

## Operation
- RAM:
  - Capacity is 2^ADDR_W words. When MMIO is enabled, only the words below the MMIO window are backed.
  - Contents are not reset. Simulation initial contents are all zeros.
- Write: when `wren`=1 at an edge, the word at `address` takes `data`.
- Read:
  - Every edge, `q` takes the word at `address`. `wren` does not gate reads.
  - Write-first: same-cycle read and write to one address returns the new `data`.
- MMIO window, when enabled: base = 2^ADDR_W − MMIO_WORDS, offsets relative to base.
  - +0 CYCLES: free-running 32-bit cycle counter, increments every edge, wraps 0xFFFF_FFFF→0. Writes ignored.
  - +1 STORES: counts accepted RAM writes, saturates at 0xFFFF_FFFF. Writes ignored. Writes to MMIO do not count.
  - +2 LED: read/write register, drives `mmio_led`, write-first like RAM.
  - +3 and above: read 0, writes dropped.
- Reset, while asserted and asynchronously on assertion:
  - `q`=0, CYCLES=0, STORES=0, LED=0.
  - RAM contents are preserved.
  - A write presented at an edge while reset is high is dropped.
- Out-of-range addresses cannot occur: `address` is exactly ADDR_W bits.

## Timing
- Read latency is 1 edge. `q` is valid after edge N for the `address` presented before edge N, and holds until the next edge.
- Write takes effect at the edge. A read issued at the following edge returns the written value.
- CYCLES read at edge N returns the count value from before edge N's increment.
- Back-to-back reads and writes are sustained every cycle. There are no stalls and no handshake.
- First edge after reset deassertion: CYCLES becomes 1, and `q` reflects `address` normally.

## Configuration
- `DMEM_RESPONDER_MMIO_EN` defined:
  - The MMIO window, counters and LED register are present.
  - The top MMIO_WORDS addresses are not RAM.
- Undefined:
  - The whole address space is RAM.
  - `mmio_led` is tied to 0.
  - No counters are instantiated.

## Structure
- `dmem_pkg` holds:
  - Default widths.
  - MMIO offset constants `MMIO_CYCLES`=0, `MMIO_STORES`=1, `MMIO_LED`=2.
  - Base-address computation function.
- One sub-module `dmem_mmio_regs` holds:
  - The counters and LED register.
  - Offset decode and the read mux into the top-level `q` select.
- The top level holds the RAM array, window decode, output register and reset.

## Test plan
- Write 0xDEADBEEF to addr 0x010, then read 0x010 on the next cycle → `q`=0xDEADBEEF one edge later.
- Same-cycle write 0x1234 and read of addr 0x020 → `q`=0x0000_1234 after that edge.
- With MMIO enabled: reset, release, wait 10 edges, read addr 0xFFC → `q`=0x0000_000A.
- With MMIO enabled: 3 RAM writes plus 1 write to 0xFFE, then read 0xFFD → 3. Read 0xFFE → written value, and `mmio_led` equals it.
- Write 0x55 to 0x030, assert reset mid-stream, read 0x030 after release → 0x55, while `q`, LED and counters were 0 during reset.
- Compiled without the macro: write and read back 0xCAFEF00D at 0xFFC → returned intact, `mmio_led`=0 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths, MMIO offsets and window-base helper for the data-memory responder.
package dmem_pkg;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MMIO_WORDS = 4;

  localparam int MMIO_CYCLES = 0;
  localparam int MMIO_STORES = 1;
  localparam int MMIO_LED    = 2;

  // Number of RAM-backed words; the MMIO window takes the top of the space when enabled.
  function automatic int mmioBase(input int addrW, input int words, input bit en);
    return en ? (1 << addrW) - words : (1 << addrW);
  endfunction
endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: cycle counter, saturating store counter, LED register and read mux.
module dmem_mmio_regs
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFF_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inWin,
  input  logic              wren,
  input  logic              ramWr,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] led
);
  logic [31:0] cycles, stores;
  logic        ledWr;

  assign ledWr = inWin && wren && (offset == OFF_W'(MMIO_LED));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycles <= '0;
      stores <= '0;
      led    <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (ramWr && stores != '1) stores <= stores + 32'd1;
      if (ledWr) led <= data;
    end
  end

  // Counters read their pre-edge value; LED is write-first like RAM.
  always_comb begin
    rdata = '0;
    if (offset == OFF_W'(MMIO_CYCLES))      rdata = DATA_W'(cycles);
    else if (offset == OFF_W'(MMIO_STORES)) rdata = DATA_W'(stores);
    else if (offset == OFF_W'(MMIO_LED))    rdata = ledWr ? data : led;
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with one-cycle registered read, write-first.
// Define DMEM_RESPONDER_MMIO_EN to map counters and an LED register at the top of the space.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MMIO_WORDS = DEF_MMIO_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] mmio_led
);
`ifdef DMEM_RESPONDER_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif
  localparam int RAM_WORDS = mmioBase(ADDR_W, MMIO_WORDS, MMIO_ON);

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic              inWin, ramWr;
  logic [DATA_W-1:0] mmioRdata;

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam int OFF_W = $clog2(MMIO_WORDS);

  assign inWin = (address >= ADDR_W'(RAM_WORDS));

  dmem_mmio_regs #(.DATA_W(DATA_W), .OFF_W(OFF_W)) uRegs (
    .clock  (clock),
    .reset  (reset),
    .inWin  (inWin),
    .wren   (wren),
    .ramWr  (ramWr),
    .offset (address[OFF_W-1:0]),
    .data   (data),
    .rdata  (mmioRdata),
    .led    (mmio_led)
  );
`else
  assign inWin     = 1'b0;
  assign mmioRdata = '0;
  assign mmio_led  = '0;
`endif

  assign ramWr = wren && !inWin;

  // RAM has no reset; a write seen while reset is high is dropped.
  always_ff @(posedge clock) begin
    if (!reset && ramWr) ram[address] <= data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (inWin) q <= mmioRdata;
    else if (wren)  q <= data;
    else            q <= ram[address];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a behavioural memory model.
module tb_dmem_responder;
  localparam int BASE = 4096 - 4;
`ifdef DMEM_RESPONDER_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q, mmio_led;

  dmem_responder dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .mmio_led (mmio_led)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    bit          qKnown;
    logic [31:0] led;
    string       tag;
  } sbItem_t;

  sbItem_t     sb[$];
  int          tests = 0;
  int          fails = 0;

  // Reference state
  logic [31:0] mem [int];
  logic [31:0] mCycles = 0, mStores = 0, mLed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: apply inputs at the negedge and predict the next edge.
  task automatic step(input bit rst, input logic [11:0] a, input logic [31:0] d,
                      input bit we, input string tag);
    sbItem_t it;
    int off;
    if (rst && !reset) begin
      reset = 1'b1;
      #1;
      check({tag, " asyncRst q"}, q, 32'h0);
      check({tag, " asyncRst led"}, mmio_led, 32'h0);
    end
    reset = rst; address = a; data = d; wren = we;
    it.tag = tag; it.qKnown = 1'b1; it.q = 32'h0;
    if (rst) begin
      mCycles = 0; mStores = 0; mLed = 0;
    end else begin
      if (MMIO && int'(a) >= BASE) begin
        off = int'(a) - BASE;
        case (off)
          0: it.q = mCycles;
          1: it.q = mStores;
          2: it.q = we ? d : mLed;
          default: it.q = 32'h0;
        endcase
        if (we && off == 2) mLed = d;
      end else if (we) begin
        it.q = d;
        mem[int'(a)] = d;
        if (mStores != 32'hFFFF_FFFF) mStores = mStores + 1;
      end else if (mem.exists(int'(a))) begin
        it.q = mem[int'(a)];
      end else begin
        it.qKnown = 1'b0;
      end
      mCycles = mCycles + 1;
    end
    it.led = mLed;
    sb.push_back(it);
    @(negedge clock);
  endtask

  // Monitor: one response per edge, compared after the edge settles.
  initial begin
    sbItem_t it;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        if (it.qKnown) check({it.tag, " q"}, q, it.q);
        check({it.tag, " led"}, mmio_led, it.led);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ra;
    @(negedge clock);
    repeat (3) step(1'b1, 12'h010, 32'hAAAA_AAAA, 1'b1, "inReset");

    // Write then read next cycle; same-cycle write/read
    step(1'b0, 12'h010, 32'hDEAD_BEEF, 1'b1, "wrDeadbeef");
    step(1'b0, 12'h010, 32'h0, 1'b0, "rdDeadbeef");
    step(1'b0, 12'h020, 32'h0000_1234, 1'b1, "wrFirst");
    step(1'b0, 12'h020, 32'h0, 1'b0, "rd1234");

    // Reset mid-stream: RAM kept, dropped write, outputs cleared
    step(1'b0, 12'h030, 32'h55, 1'b1, "wr55");
    step(1'b1, 12'h030, 32'h77, 1'b1, "rstWrDrop");
    step(1'b1, 12'hFFC, 32'h0, 1'b0, "rstRdCyc");
    step(1'b0, 12'h030, 32'h0, 1'b0, "rd55");
    step(1'b0, 12'hFFC, 32'h0, 1'b0, "rdCycAfterRst");

`ifdef DMEM_RESPONDER_MMIO_EN
    // Cycle counter after 10 edges
    step(1'b1, 12'h000, 32'h0, 1'b0, "cycRst");
    repeat (10) step(1'b0, 12'h010, 32'h0, 1'b0, "idle");
    step(1'b0, 12'hFFC, 32'h0, 1'b0, "rdCycles10");
    // Store counter and LED
    step(1'b1, 12'h000, 32'h0, 1'b0, "stRst");
    step(1'b0, 12'h040, 32'h1, 1'b1, "st1");
    step(1'b0, 12'h041, 32'h2, 1'b1, "st2");
    step(1'b0, 12'h042, 32'h3, 1'b1, "st3");
    step(1'b0, 12'hFFE, 32'h0BAD_F00D, 1'b1, "wrLed");
    step(1'b0, 12'hFFD, 32'h0, 1'b0, "rdStores");
    step(1'b0, 12'hFFE, 32'h0, 1'b0, "rdLed");
    step(1'b0, 12'hFFF, 32'h1234_5678, 1'b1, "wrRsvd");
    step(1'b0, 12'hFFF, 32'h0, 1'b0, "rdRsvd");
    step(1'b0, 12'hFFC, 32'h9, 1'b1, "wrCycIgnored");
`else
    step(1'b0, 12'hFFC, 32'hCAFE_F00D, 1'b1, "wrTop");
    step(1'b0, 12'h010, 32'h0, 1'b0, "other");
    step(1'b0, 12'hFFC, 32'h0, 1'b0, "rdTop");
`endif

    // Randomized traffic over a small RAM set plus the top words
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 12'(BASE + $urandom_range(0, 3));
      else ra = 12'(12'h100 + $urandom_range(0, 15));
      step($urandom_range(0, 49) == 0, ra, $urandom, 1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) @(posedge clock);
    #2;
    check("drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
